// File: rtl/final_onchip_memory_pipelined.sv
// final_onchip_memory_pipelined
// Single-port on-chip RAM on an Avalon-MM slave interface, with byte enables,
// a 1- or 2-stage pipelined read path with readdatavalid, and a post-reset
// clear sequencer that fills the array with CLEAR_VALUE while holding
// waitrequest.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   clken          clock enable; 0 freezes counter, state, array and pipeline
//   chipselect     slave select, qualifies read and write
//   address        word address
//   byteenable     write byte lanes
//   write, read    command strobes (write wins when both are set)
//   writedata      write data
//   readdata       read data, meaningful only while readdatavalid = 1
//   readdatavalid  one-cycle pulse per accepted read
//   waitrequest    1 = command not accepted this cycle

module final_onchip_memory_pipelined #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 12,
    parameter int unsigned           READ_LATENCY   = 1,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    write,
    input  logic                    read,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Reject unsupported configurations at elaboration
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;

    logic                    wr_acc, rd_acc;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [BYTES-1:0]        mem_be;

    logic                    rd_vld1_q;
    logic [DATA_WIDTH-1:0]   rd_data1_q;
    logic                    vld_out;
    logic [DATA_WIDTH-1:0]   data_out;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // No commands while clearing, stalled or in reset
    assign waitrequest = (state_q == ST_CLEAR) | ~clken | reset;
    assign wr_acc      = chipselect & write & ~waitrequest;
    assign rd_acc      = chipselect & read & ~write & ~waitrequest;

    // State and clear-address register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Clear sequencer: one location per enabled cycle, leave after the last one
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (clken && state_q == ST_CLEAR) begin
            clr_addr_d = ADDR_WIDTH'(clr_addr_q + 1'b1);
            if (clr_addr_q == '1) begin
                state_d = ST_READY;
            end
        end
    end

    // Write-port mux: clear sequencer owns the port while clearing
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = writedata;
        mem_be    = byteenable;
        if (state_q == ST_CLEAR) begin
            mem_we    = clken & ~reset;
            mem_addr  = clr_addr_q;
            mem_wdata = CLEAR_VALUE;
            mem_be    = '1;
        end else begin
            mem_we    = wr_acc;
        end
    end

    // Array with per-byte write enables; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // First read stage: synchronous array read, frozen while clken = 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld1_q  <= 1'b0;
            rd_data1_q <= '0;
        end else if (clken) begin
            rd_vld1_q <= rd_acc;
            if (rd_acc) begin
                rd_data1_q <= mem[address];
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_out_reg
        logic                  rd_vld2_q;
        logic [DATA_WIDTH-1:0] rd_data2_q;

        // Optional output register stage
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_vld2_q  <= 1'b0;
                rd_data2_q <= '0;
            end else if (clken) begin
                rd_vld2_q <= rd_vld1_q;
                if (rd_vld1_q) begin
                    rd_data2_q <= rd_data1_q;
                end
            end
        end

        assign vld_out  = rd_vld2_q;
        assign data_out = rd_data2_q;
    end else begin : g_no_out_reg
        assign vld_out  = rd_vld1_q;
        assign data_out = rd_data1_q;
    end

    // A held response is masked during a stall and reappears once clken returns
    assign readdatavalid = vld_out & clken;
    assign readdata      = data_out;

endmodule
